// File: rtl/riscv_apu_disp_pkg.sv
// Shared types for the APU dispatcher: latency classes and the latency-conflict rule.
package riscv_apu_disp_pkg;

    typedef enum logic [1:0] {
        LAT_SINGLE  = 2'd0,
        LAT_SINGLE1 = 2'd1,
        LAT_PIPE    = 2'd2,
        LAT_MULTI   = 2'd3
    } apu_lat_e;

    // A new op may not overlap in-flight ops if results could return out of order.
    function automatic logic lat_conflict(apu_lat_e lat, apu_lat_e lat_q);
        return (lat == LAT_SINGLE1) || (lat == LAT_MULTI) ||
               ((lat == LAT_PIPE) && (lat_q == LAT_MULTI));
    endfunction

endpackage

// File: rtl/riscv_apu_disp_tracker.sv
// In-order FIFO of outstanding destination addresses with per-slot valid bits
// exposed flat for the hazard compare.
module riscv_apu_disp_tracker
    import riscv_apu_disp_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 6,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    output logic [ADDR_W-1:0]       head_o,
    output logic [PTR_W-1:0]        head_ptr_o,
    output logic [PTR_W:0]          count_o,
    output logic [DEPTH*ADDR_W-1:0] entries_o,
    output logic [DEPTH-1:0]        valid_o
);

    logic [ADDR_W-1:0] entries_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [PTR_W:0]    cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            valid_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (push_i) begin
                entries_q[wr_q] <= waddr_i;
                valid_q[wr_q]   <= 1'b1;
                wr_q            <= wr_q + PTR_W'(1);
            end
            if (pop_i) begin
                valid_q[rd_q] <= 1'b0;
                rd_q          <= rd_q + PTR_W'(1);
            end
            if (push_i && !pop_i)      cnt_q <= cnt_q + (PTR_W+1)'(1);
            else if (pop_i && !push_i) cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

    always_comb begin
        entries_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) entries_o[i*ADDR_W +: ADDR_W] = entries_q[i];
    end

    assign head_o     = entries_q[rd_q];
    assign head_ptr_o = rd_q;
    assign count_o    = cnt_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/riscv_apu_disp_mq.sv
// APU dispatcher: issues requests, tracks outstanding ops, reports hazards and stalls.
// Optional saturating stall counters enabled by APU_DISP_PERF_EN.
module riscv_apu_disp_mq
    import riscv_apu_disp_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned NUM_RD = 3,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [1:0]               apu_lat_i,
    input  logic [ADDR_W-1:0]        apu_waddr_i,
    output logic [ADDR_W-1:0]        apu_waddr_o,
    output logic                     apu_multicycle_o,
    output logic                     apu_singlecycle_o,
    output logic                     active_o,
    output logic                     stall_o,
    input  logic [NUM_RD*ADDR_W-1:0] read_regs_i,
    input  logic [NUM_RD-1:0]        read_regs_valid_i,
    output logic                     read_dep_o,
    input  logic [NUM_WR*ADDR_W-1:0] write_regs_i,
    input  logic [NUM_WR-1:0]        write_regs_valid_i,
    output logic                     write_dep_o,
    output logic                     perf_type_o,
    output logic                     perf_cont_o,
    input  logic                     perf_clr_i,
    output logic [CNT_W-1:0]         perf_type_cnt_o,
    output logic [CNT_W-1:0]         perf_cont_cnt_o,
    output logic                     apu_master_req_o,
    output logic                     apu_master_ready_o,
    input  logic                     apu_master_gnt_i,
    input  logic                     apu_master_valid_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]       head;
    logic [PTR_W-1:0]        head_ptr;
    logic [PTR_W:0]          count;
    logic [DEPTH*ADDR_W-1:0] entries;
    logic [DEPTH-1:0]        entry_valid;
    apu_lat_e                lat_q;
    logic active, stall_full, stall_type, stall_nack;
    logic valid_req, returned_req, push, pop;

    assign active       = (count != '0);
    assign stall_full   = (count == (PTR_W+1)'(DEPTH));
    assign stall_type   = enable_i && active && lat_conflict(apu_lat_e'(apu_lat_i), lat_q);
    assign valid_req    = enable_i && !(stall_full || stall_type);
    assign stall_nack   = valid_req && !apu_master_gnt_i;
    assign returned_req = valid_req && apu_master_valid_i && !active;
    assign push         = valid_req && apu_master_gnt_i && !returned_req;
    assign pop          = apu_master_valid_i && active;

    riscv_apu_disp_tracker #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_tracker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .pop_i      (pop),
        .waddr_i    (apu_waddr_i),
        .head_o     (head),
        .head_ptr_o (head_ptr),
        .count_o    (count),
        .entries_o  (entries),
        .valid_o    (entry_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        lat_q <= LAT_SINGLE;
        else if (valid_req) lat_q <= apu_lat_e'(apu_lat_i);
    end

    // The head retiring this cycle no longer blocks; the op being issued already does.
    always_comb begin
        read_dep_o  = 1'b0;
        write_dep_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && !(pop && (head_ptr == PTR_W'(i)))) begin
                for (int unsigned p = 0; p < NUM_RD; p++)
                    if (read_regs_valid_i[p] && (read_regs_i[p*ADDR_W +: ADDR_W] == entries[i*ADDR_W +: ADDR_W]))
                        read_dep_o = 1'b1;
                for (int unsigned p = 0; p < NUM_WR; p++)
                    if (write_regs_valid_i[p] && (write_regs_i[p*ADDR_W +: ADDR_W] == entries[i*ADDR_W +: ADDR_W]))
                        write_dep_o = 1'b1;
            end
        end
        if (valid_req && !returned_req) begin
            for (int unsigned p = 0; p < NUM_RD; p++)
                if (read_regs_valid_i[p] && (read_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i))
                    read_dep_o = 1'b1;
            for (int unsigned p = 0; p < NUM_WR; p++)
                if (write_regs_valid_i[p] && (write_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i))
                    write_dep_o = 1'b1;
        end
    end

    assign apu_waddr_o        = returned_req ? apu_waddr_i : (pop ? head : '0);
    assign apu_multicycle_o   = (lat_q == LAT_MULTI);
    assign apu_singlecycle_o  = !active;
    assign active_o           = active;
    assign stall_o            = stall_full || stall_type || stall_nack;
    assign perf_type_o        = stall_type;
    assign perf_cont_o        = stall_nack;
    assign apu_master_req_o   = valid_req;
    assign apu_master_ready_o = 1'b1;

`ifdef APU_DISP_PERF_EN
    logic [CNT_W-1:0] type_cnt_q, cont_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            type_cnt_q <= '0;
            cont_cnt_q <= '0;
        end else if (perf_clr_i) begin
            type_cnt_q <= '0;
            cont_cnt_q <= '0;
        end else begin
            if (stall_type && (type_cnt_q != '1)) type_cnt_q <= type_cnt_q + CNT_W'(1);
            if (stall_nack && (cont_cnt_q != '1)) cont_cnt_q <= cont_cnt_q + CNT_W'(1);
        end
    end

    assign perf_type_cnt_o = type_cnt_q;
    assign perf_cont_cnt_o = cont_cnt_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr_i;
    assign perf_type_cnt_o = '0;
    assign perf_cont_cnt_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_ni && apu_master_valid_i && !active && !valid_req)
            $error("riscv_apu_disp_mq: response with no outstanding op");
    end

endmodule

// File: tb/tb_riscv_apu_disp_mq.sv
// Self-checking bench for riscv_apu_disp_mq: queue-based reference model plus directed literals.
module tb_riscv_apu_disp_mq;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic [1:0]  apu_lat_i = '0;
    logic [5:0]  apu_waddr_i = '0;
    logic [5:0]  apu_waddr_o;
    logic        apu_multicycle_o, apu_singlecycle_o, active_o, stall_o;
    logic [17:0] read_regs_i = '0;
    logic [2:0]  read_regs_valid_i = '0;
    logic        read_dep_o;
    logic [11:0] write_regs_i = '0;
    logic [1:0]  write_regs_valid_i = '0;
    logic        write_dep_o;
    logic        perf_type_o, perf_cont_o;
    logic        perf_clr_i = 1'b0;
    logic [31:0] perf_type_cnt_o, perf_cont_cnt_o;
    logic        apu_master_req_o, apu_master_ready_o;
    logic        apu_master_gnt_i = 1'b0;
    logic        apu_master_valid_i = 1'b0;

    int tests = 0;
    int fails = 0;

    riscv_apu_disp_mq #(
        .DEPTH(4), .ADDR_W(6), .NUM_RD(3), .NUM_WR(2), .CNT_W(32)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .apu_lat_i(apu_lat_i),
        .apu_waddr_i(apu_waddr_i), .apu_waddr_o(apu_waddr_o),
        .apu_multicycle_o(apu_multicycle_o), .apu_singlecycle_o(apu_singlecycle_o),
        .active_o(active_o), .stall_o(stall_o),
        .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i), .read_dep_o(read_dep_o),
        .write_regs_i(write_regs_i), .write_regs_valid_i(write_regs_valid_i), .write_dep_o(write_dep_o),
        .perf_type_o(perf_type_o), .perf_cont_o(perf_cont_o), .perf_clr_i(perf_clr_i),
        .perf_type_cnt_o(perf_type_cnt_o), .perf_cont_cnt_o(perf_cont_cnt_o),
        .apu_master_req_o(apu_master_req_o), .apu_master_ready_o(apu_master_ready_o),
        .apu_master_gnt_i(apu_master_gnt_i), .apu_master_valid_i(apu_master_valid_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding ops as a plain in-order queue.
    logic [5:0]  mq[$];
    logic [1:0]  mlat = '0;
    logic [31:0] mtype = '0, mcont = '0;

    function automatic logic m_vreq(input logic en, input logic [1:0] lat);
        logic busy;
        busy = mq.size() != 0;
        if (!en || mq.size() >= 4) return 1'b0;
        if (busy && (lat == 2'd1 || lat == 2'd3 || (lat == 2'd2 && mlat == 2'd3))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_dep(input logic [17:0] regs, input logic [2:0] vld, input int n,
                                   input logic skip_head, input logic incl_req, input logic [5:0] req_a);
        logic [5:0] a;
        for (int k = 0; k < mq.size(); k++) begin
            if (k == 0 && skip_head) continue;
            for (int p = 0; p < n; p++) begin
                a = regs[p*6 +: 6];
                if (vld[p] && a == mq[k]) return 1'b1;
            end
        end
        if (incl_req)
            for (int p = 0; p < n; p++) begin
                a = regs[p*6 +: 6];
                if (vld[p] && a == req_a) return 1'b1;
            end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rst_ni) begin
            mq.delete();
            mlat  = '0;
            mtype = '0;
            mcont = '0;
        end else begin
            logic busy, full, stype, vreq, ret, pop, nack;
            logic [5:0] ewa;
            busy  = mq.size() != 0;
            full  = mq.size() == 4;
            stype = enable_i && busy && (apu_lat_i == 2'd1 || apu_lat_i == 2'd3 ||
                                         (apu_lat_i == 2'd2 && mlat == 2'd3));
            vreq  = m_vreq(enable_i, apu_lat_i);
            nack  = vreq && !apu_master_gnt_i;
            ret   = vreq && apu_master_valid_i && !busy;
            pop   = apu_master_valid_i && busy;
            ewa   = ret ? apu_waddr_i : (pop ? mq[0] : 6'd0);
            chk("req", apu_master_req_o, vreq);
            chk("stall", stall_o, full || stype || nack);
            chk("waddr", apu_waddr_o, ewa);
            chk("active", active_o, busy);
            chk("single", apu_singlecycle_o, !busy);
            chk("multi", apu_multicycle_o, mlat == 2'd3);
            chk("ready", apu_master_ready_o, 1'b1);
            chk("ptype", perf_type_o, stype);
            chk("pcont", perf_cont_o, nack);
            chk("rdep", read_dep_o, m_dep(read_regs_i, read_regs_valid_i, 3, pop, vreq && !ret, apu_waddr_i));
            chk("wdep", write_dep_o, m_dep({6'd0, write_regs_i}, {1'b0, write_regs_valid_i}, 2, pop,
                                           vreq && !ret, apu_waddr_i));
`ifdef APU_DISP_PERF_EN
            chk("type_cnt", perf_type_cnt_o, mtype);
            chk("cont_cnt", perf_cont_cnt_o, mcont);
`else
            chk("type_cnt", perf_type_cnt_o, 32'd0);
            chk("cont_cnt", perf_cont_cnt_o, 32'd0);
`endif
            if (pop) void'(mq.pop_front());
            if (vreq && apu_master_gnt_i && !ret) mq.push_back(apu_waddr_i);
            if (vreq) mlat = apu_lat_i;
            if (perf_clr_i) begin
                mtype = '0;
                mcont = '0;
            end else begin
                if (stype && mtype != '1) mtype++;
                if (nack && mcont != '1) mcont++;
            end
        end
    end

    logic [17:0] rd_nx = '0;
    logic [2:0]  rdv_nx = '0;
    logic        clr_nx = 1'b0;

    // One directed cycle: drive after the edge, return where outputs are settled.
    task automatic cyc(input logic en, input logic [1:0] lat, input logic [5:0] wa,
                       input logic g, input logic v);
        @(posedge clk);
        #1;
        enable_i           = en;
        apu_lat_i          = lat;
        apu_waddr_i        = wa;
        apu_master_gnt_i   = g;
        apu_master_valid_i = v;
        read_regs_i        = rd_nx;
        read_regs_valid_i  = rdv_nx;
        write_regs_valid_i = '0;
        perf_clr_i         = clr_nx;
        rd_nx  = '0;
        rdv_nx = '0;
        clr_nx = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        #2;
        chk("rst_active", active_o, 1'b0);
        chk("rst_single", apu_singlecycle_o, 1'b1);
        chk("rst_multi", apu_multicycle_o, 1'b0);
        chk("rst_waddr", apu_waddr_o, 6'd0);
        chk("rst_stall", stall_o, 1'b0);

        cyc(1, 2'd0, 6'd5, 1, 1);
        chk("sc_waddr", apu_waddr_o, 6'd5);
        chk("sc_active", active_o, 1'b0);
        cyc(0, 2'd0, 6'd0, 0, 0);
        chk("sc_nopush", active_o, 1'b0);

        for (int i = 1; i <= 4; i++) cyc(1, 2'd2, 6'(i), 1, 0);
        cyc(1, 2'd2, 6'd5, 1, 0);
        chk("full_stall", stall_o, 1'b1);
        chk("full_req", apu_master_req_o, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 2'd0, 6'd0, 0, 1);
            chk("drain_waddr", apu_waddr_o, 6'(i));
        end

        cyc(1, 2'd2, 6'd7, 1, 0);
        cyc(1, 2'd2, 6'd8, 1, 0);
        cyc(1, 2'd2, 6'd9, 1, 1);
        chk("pp_waddr", apu_waddr_o, 6'd7);
        cyc(0, 2'd0, 6'd0, 0, 1);
        chk("pp_next8", apu_waddr_o, 6'd8);
        cyc(0, 2'd0, 6'd0, 0, 1);
        chk("pp_next9", apu_waddr_o, 6'd9);

        cyc(1, 2'd3, 6'd10, 1, 0);
        cyc(1, 2'd2, 6'd11, 1, 0);
        chk("ts_pipe", stall_o, 1'b1);
        chk("ts_ptype", perf_type_o, 1'b1);
        cyc(1, 2'd3, 6'd11, 1, 0);
        chk("ts_multi", stall_o, 1'b1);
        cyc(0, 2'd0, 6'd0, 0, 1);
        chk("ts_ret", apu_waddr_o, 6'd10);
        cyc(1, 2'd1, 6'd11, 1, 0);
        chk("ts_issue", apu_master_req_o, 1'b1);
        cyc(0, 2'd0, 6'd0, 0, 1);

        cyc(1, 2'd2, 6'd3, 1, 0);
        rd_nx = 18'd3; rdv_nx = 3'b001;
        cyc(0, 2'd0, 6'd0, 0, 1);
        chk("hz_pop", read_dep_o, 1'b0);
        cyc(1, 2'd2, 6'd3, 1, 0);
        rd_nx = 18'd3; rdv_nx = 3'b001;
        cyc(0, 2'd0, 6'd0, 0, 0);
        chk("hz_hold", read_dep_o, 1'b1);
        cyc(0, 2'd0, 6'd0, 0, 1);

        for (int i = 0; i < 3; i++) cyc(1, 2'd0, 6'd1, 0, 0);
        cyc(0, 2'd0, 6'd0, 0, 0);
`ifdef APU_DISP_PERF_EN
        chk("perf_cont3", perf_cont_cnt_o, 32'd3);
`else
        chk("perf_off", perf_cont_cnt_o, 32'd0);
`endif
        clr_nx = 1'b1;
        cyc(0, 2'd0, 6'd0, 0, 0);
        cyc(0, 2'd0, 6'd0, 0, 0);
        chk("perf_clr", perf_cont_cnt_o, 32'd0);

        for (int n = 0; n < 2000; n++) begin
            logic en, g, v;
            logic [1:0] lat;
            @(posedge clk);
            #1;
            en  = ($urandom % 4) != 0;
            lat = 2'($urandom % 4);
            g   = ($urandom % 5) != 0;
            v   = ($urandom % 2) == 1;
            v   = v && (mq.size() != 0 || m_vreq(en, lat));
            enable_i           = en;
            apu_lat_i          = lat;
            apu_waddr_i        = 6'($urandom % 8);
            apu_master_gnt_i   = g;
            apu_master_valid_i = v;
            for (int p = 0; p < 3; p++) read_regs_i[p*6 +: 6] = 6'($urandom % 8);
            for (int p = 0; p < 2; p++) write_regs_i[p*6 +: 6] = 6'($urandom % 8);
            read_regs_valid_i  = 3'($urandom);
            write_regs_valid_i = 2'($urandom);
            perf_clr_i         = ($urandom % 50) == 0;
        end

        cyc(1, 2'd2, 6'd12, 1, 0);
        cyc(1, 2'd2, 6'd13, 1, 0);
        cyc(0, 2'd0, 6'd0, 0, 0);
        @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        chk("mid_rst_active", active_o, 1'b0);
        chk("mid_rst_single", apu_singlecycle_o, 1'b1);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        cyc(0, 2'd0, 6'd0, 0, 0);
        chk("post_rst_active", active_o, 1'b0);
        repeat (5) cyc(0, 2'd0, 6'd0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
